// File: rtl/tankbatt_snd_pkg.sv
// -----------------------------------------------------------------------------
// tankbatt_snd_pkg
// Shared constants for the Tank Battalion sound generator: sound-latch bit
// indices, noise LFSR seed/taps, engine phase increments, voice gains and the
// 16-bit output saturation helper.
// -----------------------------------------------------------------------------
package tankbatt_snd_pkg;

   // Sound-latch bit assignments (bits 4-7 are stored but have no voice)
   localparam int unsigned SND_ENG_ON = 0;
   localparam int unsigned SND_ENG_HI = 1;
   localparam int unsigned SND_SHOOT  = 2;
   localparam int unsigned SND_HIT    = 3;

   // 17-bit Fibonacci noise LFSR
   localparam int unsigned LFSR_W     = 17;
   localparam logic [16:0] LFSR_SEED  = 17'h00001;
   localparam int unsigned LFSR_TAP_A = 16;
   localparam int unsigned LFSR_TAP_B = 13;

   // Engine phase step per sample tick (low / high pitch)
   localparam logic [7:0] ENG_INC_LO = 8'd2;
   localparam logic [7:0] ENG_INC_HI = 8'd3;

   // Envelope full scale and per-voice gains
   localparam logic [7:0]  ENV_MAX    = 8'd255;
   localparam int unsigned SHOOT_GAIN = 32;
   localparam int unsigned HIT_GAIN   = 48;

   // Clamp an 18-bit signed mix into the 16-bit signed PCM range
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         return 16'sh7FFF;
      else if (v < -18'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/tankbatt_snd_env.sv
// -----------------------------------------------------------------------------
// tankbatt_snd_env
// Decaying 8-bit envelope for one triggered voice (shoot or hit).
// A rising edge on the trigger level loads full scale and restarts the rate
// counter; otherwise the envelope drops by one every RATE sample ticks and
// holds at zero.
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_sample_ce one-clock sample tick
//   i_trig      trigger level (sound-latch bit)
//   o_env       current envelope value
// -----------------------------------------------------------------------------
module tankbatt_snd_env
   import tankbatt_snd_pkg::*;
#(
   parameter int unsigned RATE = 64
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sample_ce,
   input  logic       i_trig,
   output logic [7:0] o_env
);

   localparam int unsigned   CW       = (RATE > 1) ? $clog2(RATE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);

   logic          r_prev;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_env;
   logic          w_rise;

   assign w_rise = i_trig & ~r_prev;

   // A trigger on the same clock as a decrement takes priority
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_env  <= '0;
      end else begin
         r_prev <= i_trig;
         if (w_rise) begin
            r_env <= ENV_MAX;
            r_cnt <= '0;
         end else if (i_sample_ce) begin
            if (r_cnt == CNT_LAST) begin
               r_cnt <= '0;
               if (r_env != '0)
                  r_env <= r_env - 8'd1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign o_env = r_env;

endmodule

// File: rtl/tankbatt_sound.sv
// -----------------------------------------------------------------------------
// tankbatt_sound
// Tank Battalion sound generator. Decodes the CPU sound-control latch and
// mixes engine (square wave), shoot (fast noise) and hit (slow noise) voices
// into a saturated 16-bit signed PCM sample updated on a fixed sample tick.
// Ports:
//   clk_sys   system clock (18.432 MHz)
//   reset     asynchronous active-high reset
//   snd_we    one-clock write strobe to the sound latch
//   snd_addr  latch bit index
//   snd_data  value written to the selected latch bit
//   sample_ce one-clock pulse per sample tick
//   audio     signed PCM sample, held between ticks
// -----------------------------------------------------------------------------
module tankbatt_sound
   import tankbatt_snd_pkg::*;
#(
   parameter int unsigned CE_DIV     = 384,
   parameter int unsigned SHOOT_RATE = 64,
   parameter int unsigned HIT_RATE   = 256,
   parameter int unsigned ENG_AMP    = 4096
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        snd_we,
   input  logic [2:0]  snd_addr,
   input  logic        snd_data,
   output logic        sample_ce,
   output logic [15:0] audio
);

   localparam int unsigned   PW        = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(CE_DIV - 1);
   localparam logic signed [17:0] ENG_P = 18'(ENG_AMP);

   logic [7:0]        r_latch;
   logic [PW-1:0]     r_pcnt;
   logic [LFSR_W-1:0] r_lfsr;
   logic [1:0]        r_slow_cnt;
   logic              r_nz_slow;
   logic [7:0]        r_phase;
   logic signed [15:0] r_audio;

   logic              w_ce;
   logic              w_nz;
   logic [7:0]        w_env_s;
   logic [7:0]        w_env_h;
   logic [17:0]       w_shoot_mag;
   logic [17:0]       w_hit_mag;
   logic signed [17:0] w_eng;
   logic signed [17:0] w_shoot;
   logic signed [17:0] w_hit;
   logic signed [17:0] w_sum;
   logic              w_unused_latch;

   // Sound latch
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         r_latch <= '0;
      else if (snd_we)
         r_latch[snd_addr] <= snd_data;
   end

   assign w_unused_latch = &{1'b0, r_latch[7:4]};

   // Sample-tick prescaler
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         r_pcnt <= '0;
      else if (r_pcnt == PCNT_LAST)
         r_pcnt <= '0;
      else
         r_pcnt <= r_pcnt + PW'(1);
   end

   assign w_ce      = (r_pcnt == PCNT_LAST);
   assign sample_ce = w_ce;

   // Noise sources, engine phase and the output sample all advance on the tick
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_lfsr     <= LFSR_SEED;
         r_slow_cnt <= '0;
         r_nz_slow  <= 1'b0;
         r_phase    <= '0;
         r_audio    <= '0;
      end else if (w_ce) begin
         r_lfsr     <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
         r_slow_cnt <= r_slow_cnt + 2'd1;
         if (r_slow_cnt == 2'd3)
            r_nz_slow <= r_lfsr[0];
         r_phase    <= r_phase + (r_latch[SND_ENG_HI] ? ENG_INC_HI : ENG_INC_LO);
         r_audio    <= sat16(w_sum);
      end
   end

   assign w_nz = r_lfsr[0];

   tankbatt_snd_env #(.RATE(SHOOT_RATE)) u_env_shoot (
      .i_clk       (clk_sys),
      .i_rst       (reset),
      .i_sample_ce (w_ce),
      .i_trig      (r_latch[SND_SHOOT]),
      .o_env       (w_env_s)
   );

   tankbatt_snd_env #(.RATE(HIT_RATE)) u_env_hit (
      .i_clk       (clk_sys),
      .i_rst       (reset),
      .i_sample_ce (w_ce),
      .i_trig      (r_latch[SND_HIT]),
      .o_env       (w_env_h)
   );

   // Voice contributions and mix (uses pre-update register values)
   assign w_shoot_mag = 18'(w_env_s) * 18'(SHOOT_GAIN);
   assign w_hit_mag   = 18'(w_env_h) * 18'(HIT_GAIN);

   assign w_eng   = !r_latch[SND_ENG_ON] ? '0 : (r_phase[7] ? ENG_P : -ENG_P);
   assign w_shoot = w_nz      ? $signed(w_shoot_mag) : -$signed(w_shoot_mag);
   assign w_hit   = r_nz_slow ? $signed(w_hit_mag)   : -$signed(w_hit_mag);
   assign w_sum   = w_eng + w_shoot + w_hit;

   assign audio = r_audio;

endmodule

// File: tb/tb_tankbatt_sound.sv
module tb_tankbatt_sound;

   // Scaled-down timing keeps full envelope decays inside a short run;
   // a large engine amplitude forces the saturation path.
   localparam int unsigned CE   = 12;
   localparam int unsigned SR   = 4;
   localparam int unsigned HR   = 8;
   localparam int unsigned AMP  = 16384;
   localparam int          MAXT = 8192;

   logic        clk_sys  = 1'b0;
   logic        reset    = 1'b1;
   logic        snd_we   = 1'b0;
   logic [2:0]  snd_addr = '0;
   logic        snd_data = 1'b0;
   logic        sample_ce;
   logic [15:0] audio;

   int checks = 0;
   int fails  = 0;

   // Reference model: noise bit stream b_t stored at bs[t+16]
   bit         bs [0:MAXT+16];
   int         T;
   logic [7:0] m_latch;
   int         m_phase;
   int         trig_s, trig_h;
   bit         vs, vh;

   tankbatt_sound #(
      .CE_DIV     (CE),
      .SHOOT_RATE (SR),
      .HIT_RATE   (HR),
      .ENG_AMP    (AMP)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .snd_we    (snd_we),
      .snd_addr  (snd_addr),
      .snd_data  (snd_data),
      .sample_ce (sample_ce),
      .audio     (audio)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic bit nzb(int t);
      return (t < 0) ? 1'b0 : bs[t+16];
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int env_at(bit v, int t0, int rate);
      int e;
      if (!v) return 0;
      e = 255 - (T - t0) / rate;
      return (e < 0) ? 0 : e;
   endfunction

   function automatic int model_audio();
      int s;
      bit slow;
      s = 0;
      if (m_latch[0]) s += (m_phase >= 128) ? int'(AMP) : -int'(AMP);
      s += (nzb(T) ? 1 : -1) * env_at(vs, trig_s, SR) * 32;
      slow = (T >= 4) ? nzb(4 * (T / 4) - 1) : 1'b0;
      s += (slow ? 1 : -1) * env_at(vh, trig_h, HR) * 48;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic model_reset();
      T = 0; m_latch = '0; m_phase = 0; vs = 0; vh = 0; trig_s = 0; trig_h = 0;
   endtask

   // Wait for the next sample tick; returns the sampled output and the model value
   task automatic next_tick(output int obs, output int expv);
      int n;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (sample_ce !== 1'b1 && n <= int'(2 * CE));
      if (sample_ce !== 1'b1) begin
         fails++;
         $display("FAIL tick_timeout: sample_ce not seen within %0d clocks, required one per %0d", 2 * CE, CE);
         $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
         $fatal(1, "sample_ce stalled");
      end
      expv = model_audio();
      @(posedge clk_sys);
      #1;
      obs = int'($signed(audio));
      m_phase = (m_phase + (m_latch[1] ? 3 : 2)) % 256;
      T++;
   endtask

   task automatic do_write(input int unsigned a, input bit d);
      bit old;
      snd_we = 1'b1; snd_addr = 3'(a); snd_data = d;
      @(posedge clk_sys);
      #1;
      snd_we = 1'b0;
      old = m_latch[a];
      m_latch[a] = d;
      if (a == 2 && !old && d) begin vs = 1; trig_s = T; end
      if (a == 3 && !old && d) begin vh = 1; trig_h = T; end
   endtask

   task automatic test_reset();
      int obs, e;
      time t, tprev;
      logic [16:0] exp_l;
      #23;
      checks++;
      if (audio !== 16'h0 || sample_ce !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: audio=%h sample_ce=%b, required 0000/0", audio, sample_ce);
      end
      @(negedge clk_sys);
      reset = 1'b0;
      model_reset();
      tprev = 0;
      for (int i = 0; i < 100; i++) begin
         next_tick(obs, e);
         t = $time;
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL idle_audio: tick %0d audio=%0d, required %0d", i, obs, e);
         end
         if (i > 0) begin
            checks++;
            if (t - tprev != CE * 10) begin
               fails++;
               $display("FAIL ce_period: %0t between ticks, required %0d ns", t - tprev, CE * 10);
            end
         end
         tprev = t;
      end
      for (int i = 0; i < 17; i++) exp_l[i] = nzb(T - i);
      checks++;
      if (dut.r_lfsr !== exp_l) begin
         fails++;
         $display("FAIL lfsr_state: lfsr=%h, required %h", dut.r_lfsr, exp_l);
      end
   endtask

   task automatic test_engine();
      int obs, e, toggles;
      bit prev_neg;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) do_write(0, 1'b1);
         else           do_write(1, 1'b1);
         toggles = 0;
         for (int i = 0; i < 257; i++) begin
            next_tick(obs, e);
            checks++;
            if (obs !== e) begin
               fails++;
               $display("FAIL engine_audio: pass %0d tick %0d audio=%0d, required %0d", pass, i, obs, e);
            end
            if (i > 0 && ((obs < 0) != prev_neg)) toggles++;
            prev_neg = (obs < 0);
         end
         checks++;
         if (toggles != (pass == 0 ? 4 : 6)) begin
            fails++;
            $display("FAIL engine_period: pass %0d toggles=%0d in 256 ticks, required %0d",
                     pass, toggles, (pass == 0 ? 4 : 6));
         end
      end
      do_write(0, 1'b0);
   endtask

   task automatic test_shoot();
      int obs, e;
      do_write(2, 1'b1);
      for (int i = 0; i <= int'(255 * SR) + 4; i++) begin
         next_tick(obs, e);
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL shoot_audio: tick %0d audio=%0d, required %0d", i, obs, e);
         end
         if (i == 0 || i == int'(SR) || i >= int'(255 * SR)) begin
            checks++;
            if (iabs(obs) != (i == 0 ? 8160 : (i == int'(SR) ? 8128 : 0))) begin
               fails++;
               $display("FAIL shoot_level: tick %0d |audio|=%0d, required %0d", i, iabs(obs),
                        (i == 0 ? 8160 : (i == int'(SR) ? 8128 : 0)));
            end
         end
      end
   endtask

   task automatic test_hit();
      int obs, e, tt;
      bit prev_neg;
      do_write(3, 1'b1);
      for (int i = 0; i < int'(3 * HR); i++) begin
         tt = T;
         next_tick(obs, e);
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL hit_audio: tick %0d audio=%0d, required %0d", i, obs, e);
         end
         if (i == 0 || i == int'(HR)) begin
            checks++;
            if (iabs(obs) != (i == 0 ? 12240 : 12192)) begin
               fails++;
               $display("FAIL hit_level: tick %0d |audio|=%0d, required %0d", i, iabs(obs),
                        (i == 0 ? 12240 : 12192));
            end
         end
         if (i > 0) begin
            checks++;
            if (((obs < 0) != prev_neg) && (tt % 4 != 0)) begin
               fails++;
               $display("FAIL hit_slow_noise: sign change at tick index %0d, required multiple of 4", tt);
            end
         end
         prev_neg = (obs < 0);
      end
   endtask

   task automatic test_retrigger();
      int obs, e;
      // Step 0: rewrite while already 1 (no reload); 1: 0 then 1 (reload);
      // 2: rewrite mid-decay (no reload); 3: 0 then 1 mid-decay (reload)
      for (int step = 0; step < 4; step++) begin
         if (step[0]) do_write(2, 1'b0);
         do_write(2, 1'b1);
         for (int i = 0; i < int'(2 * SR) + 2; i++) begin
            next_tick(obs, e);
            checks++;
            if (obs !== e) begin
               fails++;
               $display("FAIL retrigger_audio: step %0d tick %0d audio=%0d, required %0d", step, i, obs, e);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int obs, e;
      do_write(0, 1'b1);
      do_write(3, 1'b0);
      do_write(3, 1'b1);
      do_write(2, 1'b0);
      do_write(2, 1'b1);
      for (int i = 0; i < 32; i++) begin
         next_tick(obs, e);
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL saturation_audio: tick %0d audio=%0d, required %0d", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      int obs, e;
      do_write(0, 1'b0);
      do_write(3, 1'b0);
      do_write(3, 1'b1);
      for (int i = 0; i < 6; i++) next_tick(obs, e);
      @(negedge clk_sys);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (audio !== 16'h0) begin
         fails++;
         $display("FAIL reset_async: audio=%h, required 0000", audio);
      end
      @(negedge clk_sys);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         next_tick(obs, e);
         checks++;
         if (obs !== 0 || obs !== e) begin
            fails++;
            $display("FAIL reset_silence: tick %0d audio=%0d, required 0", i, obs);
         end
      end
   endtask

   task automatic test_random();
      int obs, e, k;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++)
               do_write($urandom_range(0, 7), 1'($urandom_range(0, 1)));
         end
         next_tick(obs, e);
         checks++;
         if (obs !== e) begin
            fails++;
            $display("FAIL random_audio: tick %0d audio=%0d, required %0d", i, obs, e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) bs[i] = 1'b0;
      bs[16] = 1'b1;
      for (int t = 0; t < MAXT; t++) bs[t+17] = bs[t] ^ bs[t+3];
      model_reset();

      test_reset();
      test_engine();
      test_shoot();
      test_hit();
      test_retrigger();
      test_saturation();
      test_reset_mid();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/tankbatt_sound.md
# tankbatt_sound

Tank Battalion sound generator: decodes the CPU sound-control addressable latch and synthesizes engine, shoot and hit effects into one 16-bit signed PCM stream. Sits between the game core's sound latch writes and the `dac` instance in the MiST top level, whose `dac_i` input takes `audio` after sign-bit inversion. All synthesis runs on a fixed 48 kHz sample strobe derived from the 18.432 MHz system clock.

## Interface
- `CE_DIV`, 384: system clocks per sample tick (18.432 MHz / 384 = 48 kHz).
- `SHOOT_RATE`, 64: sample ticks per shoot-envelope decrement.
- `HIT_RATE`, 256: sample ticks per hit-envelope decrement.
- `ENG_AMP`, 4096: engine square-wave amplitude.

Ports (name, direction, width, meaning):
- `clk_sys` in 1: system clock, 18.432 MHz.
- `reset` in 1: reset, asynchronous, active-high.
- `snd_we` in 1: one-clock write strobe to the sound latch.
- `snd_addr` in 3: latch bit index.
- `snd_data` in 1: value written to the selected bit.
- `sample_ce` out 1: one-clock pulse per sample tick.
- `audio` out 16: signed PCM sample, two's complement.

## Operation
- Latch: 8 bits; on `snd_we`, `latch[snd_addr] <= snd_data`. Bit 0 is ENG_ON, bit 1 is ENG_HI, bit 2 is SHOOT, bit 3 is HIT. Bits 4-7 are stored and unused.
- Prescaler: `pcnt` counts 0..CE_DIV-1 and wraps. `sample_ce` = (`pcnt` == CE_DIV-1).
- Noise: 17-bit Fibonacci LFSR with feedback `lfsr[16]^lfsr[13]`. It shifts left on each `sample_ce`, and `nz` = `lfsr[0]`. Seed 17'h00001. The all-zero state is unreachable.
- Slow noise: `nz_slow` is sampled from `nz` every 4th sample tick, using a 2-bit counter.
- Engine: 8-bit phase accumulator adds 2 (ENG_HI=0) or 3 (ENG_HI=1) per tick. `eng` = `phase[7]` ? +ENG_AMP : −ENG_AMP when ENG_ON, else 0. The phase keeps running while ENG_ON=0.
- Shoot/hit envelopes: 8-bit `env` and a rate counter.
  - On a rising edge of the latch bit (old 0, new 1), `env` is loaded with 255 and the rate counter is cleared.
  - Otherwise, on each tick where the rate counter reaches RATE-1 and `env` > 0, `env` is decremented. It holds at 0.
  - Writing 1 to a bit that is already 1 does not retrigger.
  - A retrigger while `env` > 0 reloads 255.
- Contributions:
  - shoot = `nz` ? +env_s·32 : −env_s·32.
  - hit = `nz_slow` ? +env_h·48 : −env_h·48.
- Mix: 18-bit signed sum of eng + shoot + hit, saturated to [−32768, 32767].
  - The maximum with defaults is 24496, so no clipping occurs at defaults. Saturation logic is still mandatory for parameter overrides.

## Timing
- Reset values: `latch`=0, `pcnt`=0, `lfsr`=1, `phase`=0, both `env`=0, rate counters 0, `audio`=0, `sample_ce`=0.
- Edge detection compares the latch register with its value one clock earlier. A trigger is therefore seen the clock after the write and is acted on at that clock, independent of `sample_ce`.
- If a trigger and an envelope decrement fall on the same clock, the trigger wins.
- `audio` is registered on the clock where `sample_ce`=1, using pre-update `lfsr`, `phase` and `env` values. It is held constant between ticks.
- `audio` reflects a latch write no earlier than the next `sample_ce` at least 2 clocks after the write.
- Asserting `reset` mid-sound forces `audio`=0 immediately, asynchronously, and silences all voices.
- `snd_we` is accepted on any clock. Back-to-back writes are all applied.

## Structure
- Package `tankbatt_snd_pkg`:
  - latch bit index constants `SND_ENG_ON`, `SND_ENG_HI`, `SND_SHOOT`, `SND_HIT`;
  - LFSR seed and tap positions;
  - engine increments 2/3;
  - the shoot/hit gains 32/48.
- Sub-module `tankbatt_snd_env`, instantiated twice:
  - parameter RATE;
  - inputs: clock, reset, sample_ce, trig level;
  - output: 8-bit env;
  - contains edge detect, rate counter and decrement logic.

## Test plan
- Reset release with no writes: `sample_ce` pulses every 384 clocks; `audio` stays 0 and `lfsr` matches the reference LFSR model after 100 ticks.
- Write ENG_ON=1 with ENG_HI=0: `audio` toggles ±4096 with a period of 128 ticks. Then set ENG_HI=1: the period is about 85.3 ticks (3/256 phase step).
- Write SHOOT=1: on the next tick `|audio|` = 8160. After 64 ticks it is 8128. After 255·64 ticks it is 0 and stays 0.
- Write HIT=1 with the engine off: `|audio|` = 12240, the sign changes at most every 4 ticks, and it decrements by 48 every 256 ticks.
- Rewrite SHOOT=1 while it is already 1: no reload. Write 0 then 1 mid-decay: `env` reloads to 255. All three voices at maximum give `|audio|` ≤ 24496 with no wrap.
- Assert `reset` mid-hit: `audio` is 0 in the same cycle. After release it stays 0 until a new trigger.
